// File: rtl/byte_enable_ram.sv
// Single-port synchronous RAM with byte-lane write enables, selectable
// read-during-write behaviour, optional output stage and a clear engine.
module byte_enable_ram #(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  ADDR_WIDTH     = 12,
    parameter int                  BYTE_WIDTH     = 8,
    parameter int                  RDW_MODE       = 0,
    parameter int                  OUT_REG        = 0,
    parameter int                  CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req,
    output logic                               ready,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic                               we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               data_valid,
    input  logic                               clear,
    output logic                               busy
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    acc, rd_acc, wr_acc, upd;
    logic [DATA_WIDTH-1:0]   old_word, new_word, res_word;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    dv_q;

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q == CLEAR);
    assign acc    = req & ready;
    assign wr_acc = acc & we;
    assign rd_acc = acc & ~we;

    assign old_word = mem[addr];

    always_comb begin
        new_word = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) begin
                new_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // no-change mode leaves data_out untouched on writes
    assign upd      = rd_acc | (wr_acc & (RDW_MODE != 2));
    assign res_word = (wr_acc && RDW_MODE == 1) ? new_word : old_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_addr_q] <= CLEAR_VALUE;
        end else if (wr_acc) begin
            mem[addr] <= new_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  s1_upd_q, s1_valid_q;
            logic [DATA_WIDTH-1:0] s1_data_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_upd_q   <= 1'b0;
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    dout_q     <= '0;
                    dv_q       <= 1'b0;
                end else begin
                    s1_upd_q   <= upd;
                    s1_valid_q <= rd_acc;
                    s1_data_q  <= res_word;
                    if (s1_upd_q) begin
                        dout_q <= s1_data_q;
                    end
                    dv_q <= s1_valid_q;
                end
            end
        end else begin : g_noreg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    if (upd) begin
                        dout_q <= res_word;
                    end
                    dv_q <= rd_acc;
                end
            end
        end
    endgenerate

    assign data_out   = dout_q;
    assign data_valid = dv_q;

endmodule

// File: tb/tb_byte_enable_ram.sv
// Bench for byte_enable_ram: five configurations driven in lock-step and
// checked every cycle against a word/lane-level memory model.
module tb_byte_enable_ram;

    localparam int NI    = 5;
    localparam int DEPTH = 16;
    localparam logic [31:0] CV = 32'hDEAD_BEEF;
    localparam int RDW_T  [NI] = '{0, 1, 2, 0, 1};
    localparam int OREG_T [NI] = '{0, 0, 0, 1, 1};
    localparam int COR_T  [NI] = '{1, 1, 1, 1, 0};

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  addr  = '0;
    logic [3:0]  be    = '0;
    logic [31:0] din   = '0;
    logic        clear = 1'b0;

    logic [NI-1:0] rdy, bsy, dv;
    logic [31:0]   dout [NI];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] mm     [NI][DEPTH];
    int          left   [NI];
    int          pos    [NI];
    logic [31:0] e_dout [NI];
    logic [31:0] p_data [NI];
    bit          e_dv   [NI];
    bit          p_upd  [NI];
    bit          p_v    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        byte_enable_ram #(
            .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
            .RDW_MODE(RDW_T[g]), .OUT_REG(OREG_T[g]),
            .CLEAR_ON_RESET(COR_T[g]), .CLEAR_VALUE(CV)
        ) u_dut (
            .clk(clk), .reset(reset), .req(req), .ready(rdy[g]),
            .addr(addr), .we(we), .be(be), .data_in(din),
            .data_out(dout[g]), .data_valid(dv[g]),
            .clear(clear), .busy(bsy[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            left[k]   = (COR_T[k] != 0) ? DEPTH : 0;
            pos[k]    = 0;
            e_dout[k] = '0;
            e_dv[k]   = 1'b0;
            p_upd[k]  = 1'b0;
            p_v[k]    = 1'b0;
            p_data[k] = '0;
        end
    endtask

    // One clock edge of behaviour, from the inputs presented before it.
    task automatic model_step();
        logic [31:0] old, merged, r_data;
        bit acc, r_upd, r_v;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            acc    = req && (left[k] == 0);
            old    = mm[k][addr];
            merged = old;
            for (int b = 0; b < 4; b++)
                if (be[b]) merged[b*8 +: 8] = din[b*8 +: 8];
            r_upd  = 1'b0;
            r_v    = 1'b0;
            r_data = old;
            if (acc && !we) begin
                r_upd = 1'b1;
                r_v   = 1'b1;
            end else if (acc && we) begin
                r_upd  = (RDW_T[k] != 2);
                r_data = (RDW_T[k] == 1) ? merged : old;
            end
            if (OREG_T[k] != 0) begin
                if (p_upd[k]) e_dout[k] = p_data[k];
                e_dv[k]   = p_v[k];
                p_upd[k]  = r_upd;
                p_data[k] = r_data;
                p_v[k]    = r_v;
            end else begin
                if (r_upd) e_dout[k] = r_data;
                e_dv[k] = r_v;
            end
            if (acc && we) mm[k][addr] = merged;
            if (left[k] != 0) begin
                mm[k][pos[k]] = CV;
                pos[k]++;
                left[k]--;
            end else if (clear) begin
                left[k] = DEPTH;
                pos[k]  = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("u%0d ready", k), 32'(rdy[k]), 32'(left[k] == 0));
                chk($sformatf("u%0d busy", k), 32'(bsy[k]), 32'(left[k] != 0));
                chk($sformatf("u%0d data_valid", k), 32'(dv[k]), 32'(e_dv[k]));
                chk($sformatf("u%0d data_out", k), dout[k], e_dout[k]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_reset(input bit v);
        reset = v;
        if (v) begin
            req   = 1'b0;
            clear = 1'b0;
            model_reset();
        end
    endtask

    task automatic op(input bit r, input bit w, input logic [3:0] a,
                      input logic [3:0] b, input logic [31:0] d);
        req  = r;
        we   = w;
        addr = a;
        be   = b;
        din  = d;
        cyc();
    endtask

    task automatic wait_busy(input int u, output int n);
        n = 0;
        while (bsy[u] && n < 64) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_all_idle();
        int n = 0;
        while (|bsy && n < 64) begin
            cyc();
            n++;
        end
        chk("sweep terminates", 32'(|bsy), 32'd0);
    endtask

    initial begin
        int n;
        #1;
        set_reset(1'b1);
        chk_en = 1'b1;
        cyc();
        cyc();
        chk("reset data_out", dout[0], 32'd0);
        chk("reset data_valid", 32'(dv[3]), 32'd0);
        chk("reset busy cor1", 32'(bsy[0]), 32'd1);
        chk("reset ready cor0", 32'(rdy[4]), 32'd1);

        // power-up sweep; the cor0 copy is cleared by an explicit request
        set_reset(1'b0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        n = 1;
        while (bsy[0] && n < 64) begin
            cyc();
            n++;
        end
        chk("power-up busy cycles", n, 32'd16);
        wait_all_idle();
        op(1, 0, 4'd0, 4'h0, '0);
        chk("read addr0 clear value", dout[0], CV);
        chk("read addr0 valid", 32'(dv[0]), 32'd1);
        op(1, 0, 4'd15, 4'h0, '0);
        chk("read addr15 clear value", dout[0], CV);
        op(0, 0, 4'd0, 4'h0, '0);
        chk("single valid pulse", 32'(dv[0]), 32'd0);

        // byte enables
        op(1, 1, 4'd3, 4'hF, 32'hAABB_CCDD);
        op(1, 1, 4'd3, 4'h5, 32'h1122_3344);
        op(1, 0, 4'd3, 4'h0, '0);
        chk("byte merge", dout[0], 32'hAA22_CC44);
        op(1, 1, 4'd3, 4'h0, 32'hFFFF_FFFF);
        op(1, 0, 4'd3, 4'h0, '0);
        chk("be=0 no-op", dout[0], 32'hAA22_CC44);

        // read-during-write modes
        op(1, 1, 4'd7, 4'hF, 32'h0102_0304);
        op(1, 1, 4'd5, 4'hF, 32'h5555_5555);
        op(1, 0, 4'd5, 4'h0, '0);
        op(1, 1, 4'd7, 4'h3, 32'hFFFF_FFFF);
        chk("rdw read-first", dout[0], 32'h0102_0304);
        chk("rdw write-first", dout[1], 32'h0102_FFFF);
        chk("rdw no-change", dout[2], 32'h5555_5555);
        chk("rdw valid low", 32'(dv[2:0]), 32'd0);

        // latency and throughput
        for (int i = 0; i < 4; i++) op(1, 1, 4'(i), 4'hF, 32'(10 + i));
        for (int i = 0; i < 6; i++) begin
            op(i < 4, 0, 4'(i), 4'h0, '0);
            chk($sformatf("oreg1 valid %0d", i), 32'(dv[3]),
                32'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4)
                chk($sformatf("oreg1 data %0d", i), dout[3], 32'(9 + i));
            if (i <= 3)
                chk($sformatf("oreg0 data %0d", i), dout[0], 32'(10 + i));
        end

        // requests dropped while sweeping
        req   = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear raises busy", 32'(bsy[0]), 32'd1);
        chk("ready low in sweep", 32'(rdy[0]), 32'd0);
        req  = 1'b1;
        we   = 1'b1;
        addr = 4'd2;
        be   = 4'hF;
        din  = 32'h1234_5678;
        n = 0;
        while (bsy[0] && n < 64) begin
            clear = (n == 5);
            cyc();
            n++;
        end
        req   = 1'b0;
        clear = 1'b0;
        chk("sweep length with clear pulse", n, 32'd16);
        op(1, 0, 4'd2, 4'h0, '0);
        chk("dropped write", dout[0], CV);

        // reset in the middle of a sweep
        op(0, 0, 4'd0, 4'h0, '0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        repeat (9) cyc();
        set_reset(1'b1);
        #1;
        chk("mid-sweep reset data_out", dout[0], 32'd0);
        chk("mid-sweep reset busy", 32'(bsy[0]), 32'd1);
        chk("mid-sweep reset cor0 ready", 32'(rdy[4]), 32'd1);
        cyc();
        set_reset(1'b0);
        wait_busy(0, n);
        chk("restarted sweep length", n, 32'd16);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                set_reset(1'b1);
                cyc();
                set_reset(1'b0);
            end
            req   = ($urandom_range(9) < 7);
            we    = ($urandom_range(1) == 1);
            addr  = 4'($urandom_range(15));
            be    = 4'($urandom);
            din   = $urandom;
            clear = ($urandom_range(149) == 0);
            cyc();
        end
        req   = 1'b0;
        clear = 1'b0;
        repeat (3) cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
